pipe_ctrl: RTL and testbench

- Pipeline control unit for the 5-stage Y86 core. Produces the stall and bubble controls consumed by the F, F/D, D/E, E/M and M/W pipeline registers, including the E_bubble input of the decode-to-execute register.
- Detects load-use hazards, jump mispredicts and ret hazards.
- Freezes the pipe on a multi-cycle data-memory handshake, with timeout.
- Latches a sticky halt when a terminating status reaches write-back.

---
 rtl/pipe_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage Y86 core: stall/bubble generation for the
// F, F/D, D/E, E/M and M/W registers, data-memory freeze with timeout, sticky halt.
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int RET_BUBBLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    input  logic [3:0] M_icode,
    input  logic       dmem_ready,
    input  logic       W_halt,
    output logic       F_stall,
    output logic       D_stall,
    output logic       D_bubble,
    output logic       E_stall,
    output logic       E_bubble,
    output logic       M_stall,
    output logic       M_bubble,
    output logic       W_stall,
    output logic       halted,
    output logic       mem_err
);

    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPL   = 4'hB;
    localparam logic [3:0] RNONE    = 4'hF;

    localparam logic [1:0] RET_LOAD    = 2'(RET_BUBBLES - 1);
    localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        RET_HOLD = 2'd1,
        MEM_WAIT = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t     state_q, state_n;
    logic [1:0] ret_cnt_q, ret_cnt_n;
    logic [7:0] wait_cnt_q, wait_cnt_n;
    logic       halted_q, halted_n;
    logic       mem_err_q, mem_err_n;

    logic       mem_freeze;
    logic       mispredict;
    logic       load_use;
    logic [8:0] wait_inc;

    function automatic logic is_memop(input logic [3:0] icode);
        case (icode)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_memop = 1'b1;
            default:                            is_memop = 1'b0;
        endcase
    endfunction

    function automatic logic is_load_use(input logic [3:0] e_icode, input logic [3:0] e_dstm,
                                         input logic [3:0] src_a, input logic [3:0] src_b);
        is_load_use = ((e_icode == I_MRMOVL) || (e_icode == I_POPL)) &&
                      (e_dstm != RNONE) && ((e_dstm == src_a) || (e_dstm == src_b));
    endfunction

    assign mem_freeze = is_memop(M_icode) && !dmem_ready;
    assign mispredict = (E_icode == I_JXX) && !e_Cnd;
    assign load_use   = is_load_use(E_icode, E_dstM, d_srcA, d_srcB);
    // Widened so a count at 255 cannot wrap before the timeout compare.
    assign wait_inc   = {1'b0, wait_cnt_q} + 9'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            ret_cnt_q  <= 2'd0;
            wait_cnt_q <= 8'd0;
            halted_q   <= 1'b0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_n;
            ret_cnt_q  <= ret_cnt_n;
            wait_cnt_q <= wait_cnt_n;
            halted_q   <= halted_n;
            mem_err_q  <= mem_err_n;
        end
    end

    always_comb begin
        F_stall    = 1'b0;
        D_stall    = 1'b0;
        D_bubble   = 1'b0;
        E_stall    = 1'b0;
        E_bubble   = 1'b0;
        M_stall    = 1'b0;
        M_bubble   = 1'b0;
        W_stall    = 1'b0;
        state_n    = state_q;
        ret_cnt_n  = ret_cnt_q;
        wait_cnt_n = 8'd0;
        halted_n   = halted_q;
        mem_err_n  = mem_err_q;

        if (!rst) begin
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
        end else if (state_q == HALTED) begin
            F_stall = 1'b1;
            D_stall = 1'b1;
            E_stall = 1'b1;
            M_stall = 1'b1;
            W_stall = 1'b1;
        end else if (mem_freeze) begin
            // Everything up to E/M holds; the write-back instruction still retires.
            F_stall    = 1'b1;
            D_stall    = 1'b1;
            E_stall    = 1'b1;
            M_stall    = 1'b1;
            wait_cnt_n = wait_inc[7:0];
            if (wait_inc >= TIMEOUT_LIM) begin
                state_n   = HALTED;
                mem_err_n = 1'b1;
            end else begin
                state_n = MEM_WAIT;
            end
        end else if (W_halt) begin
            M_bubble = 1'b1;
            W_stall  = 1'b1;
            state_n  = HALTED;
            halted_n = 1'b1;
        end else if (mispredict) begin
            // The squashed path may hold a ret in D; it must not start a hold.
            D_bubble  = 1'b1;
            E_bubble  = 1'b1;
            ret_cnt_n = 2'd0;
            state_n   = RUN;
        end else if (load_use) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_bubble = 1'b1;
            state_n  = (ret_cnt_q != 2'd0) ? RET_HOLD : RUN;
        end else if (ret_cnt_q != 2'd0) begin
            F_stall   = 1'b1;
            D_bubble  = 1'b1;
            ret_cnt_n = ret_cnt_q - 2'd1;
            state_n   = (ret_cnt_q == 2'd1) ? RUN : RET_HOLD;
        end else if (D_icode == I_RET) begin
            F_stall   = 1'b1;
            D_bubble  = 1'b1;
            ret_cnt_n = RET_LOAD;
            state_n   = (RET_LOAD != 2'd0) ? RET_HOLD : RUN;
        end else begin
            state_n = RUN;
        end
    end

    assign halted  = halted_q;
    assign mem_err = mem_err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazard, ret-hold, memory freeze/timeout and halt
// sequences checked against hand-computed control vectors.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic       e_Cnd, dmem_ready, W_halt;
    logic       F_stall, D_stall, D_bubble, E_stall, E_bubble;
    logic       M_stall, M_bubble, W_stall, halted, mem_err;

    int n_cmp = 0;
    int n_err = 0;

    // Vector order: F_stall D_stall D_bubble E_stall E_bubble M_stall M_bubble W_stall halted mem_err
    localparam logic [9:0] V_IDLE = 10'h000;
    localparam logic [9:0] V_RST  = 10'h0A8;
    localparam logic [9:0] V_LU   = 10'h320;
    localparam logic [9:0] V_RET  = 10'h280;
    localparam logic [9:0] V_MISP = 10'h0A0;
    localparam logic [9:0] V_FRZ  = 10'h350;
    localparam logic [9:0] V_HMEM = 10'h355;
    localparam logic [9:0] V_WHLT = 10'h00C;
    localparam logic [9:0] V_HW   = 10'h356;

    pipe_ctrl #(.MEM_TIMEOUT(16), .RET_BUBBLES(3)) dut (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .dmem_ready(dmem_ready), .W_halt(W_halt),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_stall(E_stall), .E_bubble(E_bubble), .M_stall(M_stall),
        .M_bubble(M_bubble), .W_stall(W_stall), .halted(halted), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] di, input logic [3:0] sa, input logic [3:0] sb,
                         input logic [3:0] ei, input logic [3:0] edm, input logic ec,
                         input logic [3:0] mi, input logic rdy, input logic wh);
        D_icode = di; d_srcA = sa; d_srcB = sb;
        E_icode = ei; E_dstM = edm; e_Cnd = ec;
        M_icode = mi; dmem_ready = rdy; W_halt = wh;
    endtask

    task automatic nops();
        drive(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 1'b1, 1'b0);
    endtask

    task automatic chk(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        obs = {F_stall, D_stall, D_bubble, E_stall, E_bubble,
               M_stall, M_bubble, W_stall, halted, mem_err};
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are applied 1 time unit after a rising edge; outputs are checked
    // 3 units later, then the bench advances past the next rising edge.
    task automatic cyc(input string tag, input logic [9:0] exp);
        #3;
        chk(tag, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        nops();
        #2;
        chk("reset_outputs", V_RST);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc("idle_first", V_IDLE);
        cyc("idle_second", V_IDLE);

        // Load-use hazards
        drive(4'h6, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 1'b1, 1'b0);
        cyc("lu_mrmovl_srcA", V_LU);
        nops();
        cyc("lu_released", V_IDLE);
        drive(4'h6, 4'h2, 4'h4, 4'hB, 4'h4, 1'b1, 4'h1, 1'b1, 1'b0);
        cyc("lu_popl_srcB", V_LU);
        drive(4'h6, 4'hF, 4'hF, 4'h5, 4'hF, 1'b1, 4'h1, 1'b1, 1'b0);
        cyc("lu_rnone_no_stall", V_IDLE);
        drive(4'h6, 4'h3, 4'h3, 4'h6, 4'h3, 1'b1, 4'h1, 1'b1, 1'b0);
        cyc("lu_not_load_op", V_IDLE);

        // Ret: exactly three held cycles
        drive(4'h9, 4'h4, 4'h4, 4'h1, 4'hF, 1'b1, 4'h1, 1'b1, 1'b0);
        cyc("ret_c0", V_RET);
        nops();
        cyc("ret_c1", V_RET);
        cyc("ret_c2", V_RET);
        cyc("ret_done", V_IDLE);

        // Mispredict squashes a ret in D
        drive(4'h9, 4'h4, 4'h4, 4'h7, 4'hF, 1'b0, 4'h1, 1'b1, 1'b0);
        cyc("misp_ret_squash", V_MISP);
        nops();
        cyc("misp_no_hold_1", V_IDLE);
        cyc("misp_no_hold_2", V_IDLE);
        drive(4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 4'h1, 1'b1, 1'b0);
        cyc("jxx_taken", V_IDLE);

        // Memory freeze in the middle of a ret hold
        drive(4'h9, 4'h4, 4'h4, 4'h1, 4'hF, 1'b1, 4'h1, 1'b1, 1'b0);
        cyc("rf_ret_c0", V_RET);
        nops();
        cyc("rf_ret_c1", V_RET);
        drive(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h5, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc("rf_freeze", V_FRZ);
        nops();
        cyc("rf_ret_resume", V_RET);
        cyc("rf_ret_done", V_IDLE);

        // Load-use takes precedence over ret in D; hold starts when ret advances
        drive(4'h9, 4'h3, 4'h4, 4'h5, 4'h3, 1'b1, 4'h1, 1'b1, 1'b0);
        cyc("lu_over_ret", V_LU);
        drive(4'h9, 4'h4, 4'h4, 4'h1, 4'hF, 1'b1, 4'h1, 1'b1, 1'b0);
        cyc("lu_ret_c0", V_RET);
        nops();
        cyc("lu_ret_c1", V_RET);
        cyc("lu_ret_c2", V_RET);
        cyc("lu_ret_done", V_IDLE);

        // Wait counter clears between accesses: two 15-cycle waits never time out
        drive(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'hA, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) cyc("wait15_a", V_FRZ);
        dmem_ready = 1'b1;
        cyc("wait15_gap", V_IDLE);
        dmem_ready = 1'b0;
        for (int i = 0; i < 15; i++) cyc("wait15_b", V_FRZ);
        nops();
        cyc("wait15_done", V_IDLE);

        // Timeout after 16 low cycles
        drive(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h5, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cyc("tmo_freeze", V_FRZ);
        cyc("tmo_halted", V_HMEM);
        nops();
        cyc("tmo_sticky", V_HMEM);
        W_halt = 1'b1;
        cyc("tmo_ignores_whalt", V_HMEM);
        nops();

        // Reset aborts HALTED
        rst = 1'b0;
        cyc("rst_mid_halt", V_RST);
        rst = 1'b1;
        cyc("rst_cleared", V_IDLE);

        // Reset aborts a ret hold
        drive(4'h9, 4'h4, 4'h4, 4'h1, 4'hF, 1'b1, 4'h1, 1'b1, 1'b0);
        cyc("ra_ret_c0", V_RET);
        nops();
        rst = 1'b0;
        cyc("ra_rst", V_RST);
        rst = 1'b1;
        cyc("ra_no_hold", V_IDLE);

        // W_halt sets sticky halted
        W_halt = 1'b1;
        cyc("whalt_cycle", V_WHLT);
        W_halt = 1'b0;
        cyc("whalt_sticky_1", V_HW);
        drive(4'h9, 4'h3, 4'h3, 4'h5, 4'h3, 1'b0, 4'h5, 1'b0, 1'b0);
        cyc("whalt_sticky_2", V_HW);
        nops();
        cyc("whalt_sticky_3", V_HW);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
